mem_port_arbiter: RTL and testbench

Shares one sram-like memory port between the instruction-fetch requester (IF) and the load/store requester (MEM). It keeps at most one transaction outstanding and sequences each one through a three-state handshake machine. Data accesses have priority, and a bounded starvation counter protects instruction fetch. The block sits between the pipeline stages and the external memory interface in the CPU top.

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one sram-like memory port between instruction fetch and load/store,
// with data priority, a starvation guard for fetch and one transaction in flight.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [1:0] SMAX = 2'(STARVE_MAX);

  state_t      state, state_nx;
  logic        owner;
  logic [1:0]  starve_cnt;
  logic        grant_inst, grant_data, done;

  // Grants are gated by rst so no addr_ok can escape while reset is held.
  always_comb begin
    state_nx   = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (rst) begin
          if (data_req && !(inst_req && starve_cnt == SMAX)) grant_data = 1'b1;
          else if (inst_req)                                  grant_inst = 1'b1;
        end
        if (grant_inst || grant_data) state_nx = ADDR;
      end
      ADDR: if (mem_addr_ok) state_nx = DATA;
      DATA: begin
        if (mem_data_ok) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = done && !owner;
  assign data_data_ok = done && owner;
  assign inst_rdata   = (done && !owner) ? mem_rdata : '0;
  assign data_rdata   = (done && owner)  ? mem_rdata : '0;
  assign mem_req      = (state == ADDR);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      starve_cnt <= '0;
      mem_wr     <= 1'b0;
      mem_size   <= '0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nx;
      if (grant_data) begin
        owner      <= 1'b1;
        mem_wr     <= data_wr;
        mem_size   <= data_size;
        mem_wstrb  <= data_wstrb;
        mem_addr   <= data_addr;
        mem_wdata  <= data_wdata;
        starve_cnt <= !inst_req ? '0 :
                      (starve_cnt == 2'b11) ? starve_cnt : starve_cnt + 2'd1;
      end else if (grant_inst) begin
        owner      <= 1'b0;
        mem_wr     <= 1'b0;
        mem_size   <= 2'd2;
        mem_wstrb  <= '0;
        mem_addr   <= inst_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written starvation, stray-response, reset and back-to-back sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr, busy;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        is_inst;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ret;
    int          aw;
    int          dw;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    inst_req   = v.is_inst;
    data_req   = !v.is_inst;
    inst_addr  = v.addr;
    data_addr  = v.is_inst ? 32'h5555_0000 : v.addr;
    data_wr    = v.wr;
    data_size  = v.size;
    data_wstrb = v.wstrb;
    data_wdata = v.wdata;
    @(negedge clk);
    chk("busy_at_grant", busy, 0);
    chk("inst_addr_ok", inst_addr_ok, 32'(v.is_inst));
    chk("data_addr_ok", data_addr_ok, 32'(!v.is_inst));
    tick();
    inst_req = 0; data_req = 0;
    inst_addr = '1; data_addr = '1; data_wdata = '1;
    data_wr = ~v.wr; data_size = ~v.size; data_wstrb = ~v.wstrb;
    for (int w = 0; w <= v.aw; w++) begin
      mem_addr_ok = (w == v.aw);
      @(negedge clk);
      chk("addr_mem_req", mem_req, 1);
      chk("addr_busy", busy, 1);
      chk("addr_mem_addr", mem_addr, v.addr);
      chk("addr_mem_wr", mem_wr, 32'(v.exp_wr));
      chk("addr_mem_size", mem_size, 32'(v.exp_size));
      chk("addr_mem_wstrb", mem_wstrb, 32'(v.exp_wstrb));
      if (!v.is_inst) chk("addr_mem_wdata", mem_wdata, v.wdata);
      tick();
    end
    mem_addr_ok = 0;
    for (int w = 0; w <= v.dw; w++) begin
      mem_data_ok = (w == v.dw);
      mem_rdata   = v.ret;
      @(negedge clk);
      chk("data_mem_req", mem_req, 0);
      chk("data_busy", busy, 1);
      chk("inst_data_ok", inst_data_ok, 32'((w == v.dw) && v.is_inst));
      chk("data_data_ok", data_data_ok, 32'((w == v.dw) && !v.is_inst));
      if (w == v.dw) begin
        chk("owner_rdata", v.is_inst ? inst_rdata : data_rdata, v.ret);
        chk("other_rdata", v.is_inst ? data_rdata : inst_rdata, 0);
      end
      tick();
    end
    mem_data_ok = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    vecs[0] = '{1'b1, 1'b1, 2'd0, 4'hF, 32'hBFC0_0000, 32'h0, 32'h3C1D_0000, 0, 0, 1'b0, 2'd2, 4'h0};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 4'b0100, 32'h8000_0002, 32'h00AB_0000, 32'h0, 2, 0, 1'b1, 2'd0, 4'b0100};
    vecs[2] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h8000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0, 2'd2, 4'h0};
    vecs[3] = '{1'b0, 1'b0, 2'd1, 4'h0, 32'h8000_0006, 32'h0, 32'h1234_ABCD, 1, 2, 1'b0, 2'd1, 4'h0};
    vecs[4] = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0, 2'd2, 4'h0};

    rst = 0; inst_req = 0; data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_size", mem_size, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    repeat (2) tick();
    rst = 1;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Stray responses in IDLE and ADDR
    mem_data_ok = 1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("stray_idle_inst_dok", inst_data_ok, 0);
    chk("stray_idle_data_dok", data_data_ok, 0);
    tick();
    chk("stray_idle_busy", busy, 0);
    data_req = 1; data_addr = 32'h8000_0040; data_wr = 0; data_size = 2;
    tick();
    data_req = 0;
    @(negedge clk);
    chk("stray_addr_inst_dok", inst_data_ok, 0);
    chk("stray_addr_data_dok", data_data_ok, 0);
    tick();
    chk("stray_addr_held", mem_req, 1);
    mem_data_ok = 0; mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("stray_finish_dok", data_data_ok, 1);
    tick();
    mem_data_ok = 0;

    // Contention: both held high, expect D D D I D D D I
    pat = 8'h88;
    inst_req = 1; inst_addr = 32'h0000_0200;
    data_req = 1; data_addr = 32'h0000_0100; data_wr = 0; data_size = 2;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("starve_inst_aok", inst_addr_ok, 32'(pat[i]));
      chk("starve_data_aok", data_addr_ok, 32'(!pat[i]));
      tick();
      mem_addr_ok = 1;
      @(negedge clk);
      chk("starve_mem_addr", mem_addr, pat[i] ? 32'h0000_0200 : 32'h0000_0100);
      tick();
      mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'(i);
      @(negedge clk);
      chk("starve_inst_dok", inst_data_ok, 32'(pat[i]));
      chk("starve_data_dok", data_data_ok, 32'(!pat[i]));
      chk("no_grant_at_done", 32'(inst_addr_ok | data_addr_ok), 0);
      tick();
      mem_data_ok = 0;
    end
    inst_req = 0; data_req = 0;
    tick();

    // Reset during DATA
    inst_req = 1; inst_addr = 32'h0000_0300;
    tick();
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0;
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 0; mem_data_ok = 1; mem_rdata = 32'h9999_9999;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_size", mem_size, 0);
    chk("midrst_inst_aok", inst_addr_ok, 0);
    chk("midrst_inst_dok", inst_data_ok, 0);
    chk("midrst_inst_rdata", inst_rdata, 0);
    tick();
    inst_req = 0;
    rst = 1;
    @(negedge clk);
    chk("late_dok_inst", inst_data_ok, 0);
    chk("late_dok_data", data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    run_txn(vecs[0]);

    // Back-to-back data: next addr_ok one cycle after completion
    data_req = 1; data_addr = 32'h8000_0080; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_wdata = 32'h0102_0304;
    tick();
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; mem_data_ok = 1;
    @(negedge clk);
    chk("b2b_done", data_data_ok, 1);
    chk("b2b_no_grant", data_addr_ok, 0);
    tick();
    mem_data_ok = 0;
    @(negedge clk);
    chk("b2b_next_grant", data_addr_ok, 1);
    tick();
    data_req = 0;
    chk("b2b_mem_wdata", mem_wdata, 32'h0102_0304);
    mem_addr_ok = 1;
    tick();
    mem_addr_ok = 0; mem_data_ok = 1;
    tick();
    mem_data_ok = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
